// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit engine: pulls words from a FWFT FIFO and serializes start, data (LSB first),
// optional parity and 1/2 stop bits at one bit per CLK, with gapless back-to-back frames.
module uart_tx_frame_ctrl #(
   parameter  int DATA_WIDTH = 8,
   localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  f_empty,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   output logic                  rd_inc,
   output logic                  TX_OUT,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP1  = 3'd4,
      S_STOP2  = 3'd5
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic                    par_en_q, par_en_d;
   logic                    stop2_q, stop2_d;
   logic                    par_q, par_d;
   logic                    tx_q, tx_d;
   logic                    busy_q, busy_d;
   logic                    last_stop;
   logic                    accept;

   // A new word may be taken only when the line would otherwise go idle next cycle.
   assign last_stop = ((state_q == S_STOP1) && !stop2_q) || (state_q == S_STOP2);
   assign accept    = RST && !f_empty && ((state_q == S_IDLE) || last_stop);
   assign rd_inc    = accept;
   assign TX_OUT    = tx_q;
   assign busy      = busy_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         par_en_q <= par_en_d;
         stop2_q  <= stop2_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = accept ? S_START : S_IDLE;
         S_START:  state_d = S_DATA;
         S_DATA:   if (cnt_q == CNT_W'(DATA_WIDTH-1))
                      state_d = par_en_q ? S_PARITY : S_STOP1;
         S_PARITY: state_d = S_STOP1;
         S_STOP1:  if (stop2_q) state_d = S_STOP2;
                   else         state_d = accept ? S_START : S_IDLE;
         S_STOP2:  state_d = accept ? S_START : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath next-state: config is sampled only on the accept edge.
   always_comb begin
      cnt_d    = '0;
      shift_d  = shift_q;
      par_en_d = par_en_q;
      stop2_d  = stop2_q;
      par_d    = par_q;
      if (state_q == S_DATA && state_d == S_DATA)
         cnt_d = cnt_q + CNT_W'(1);
      if (accept) begin
         shift_d  = P_DATA;
         par_en_d = PAR_EN;
         stop2_d  = STOP2;
         par_d    = (^P_DATA) ^ PAR_TYP;
      end else if (state_d == S_DATA) begin
         shift_d  = shift_q >> 1;
      end
   end

   // Line value follows the state being entered, so each state lasts one bit time.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = 1'b0;
      case (state_d)
         S_IDLE:   begin tx_d = 1'b1;       busy_d = 1'b0; end
         S_START:  begin tx_d = 1'b0;       busy_d = 1'b1; end
         S_DATA:   begin tx_d = shift_q[0]; busy_d = 1'b1; end
         S_PARITY: begin tx_d = par_q;      busy_d = 1'b1; end
         S_STOP1:  begin tx_d = 1'b1;       busy_d = 1'b1; end
         S_STOP2:  begin tx_d = 1'b1;       busy_d = 1'b1; end
         default:  begin tx_d = 1'b1;       busy_d = 1'b0; end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl: table of single frames plus back-to-back,
// mid-frame config change, mid-frame reset and a 7-bit instance.
module tb_uart_tx_frame_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic [8:0] P_DATA;
   logic       f_empty, f_empty7;
   logic       PAR_EN, PAR_TYP, STOP2;
   logic       rd8, tx8, busy8;
   logic       rd7, tx7, busy7;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   uart_tx_frame_ctrl #(.DATA_WIDTH(8)) u_dut8 (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA[7:0]), .f_empty(f_empty),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
      .rd_inc(rd8), .TX_OUT(tx8), .busy(busy8)
   );

   uart_tx_frame_ctrl #(.DATA_WIDTH(7)) u_dut7 (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA[6:0]), .f_empty(f_empty7),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
      .rd_inc(rd7), .TX_OUT(tx7), .busy(busy7)
   );

   typedef struct {
      logic [8:0]  data;
      logic        pe, pt, s2;
      int          len;
      logic [0:11] exp;   // index 0 = first bit on the line
      bit          w7;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic g_tx(input bit w7);   return w7 ? tx7 : tx8;     endfunction
   function automatic logic g_busy(input bit w7); return w7 ? busy7 : busy8; endfunction
   function automatic logic g_rd(input bit w7);   return w7 ? rd7 : rd8;     endfunction

   task automatic set_empty(input bit w7, input logic v);
      if (w7) f_empty7 = v; else f_empty = v;
   endtask

   task automatic run_frame(input vec_t v, input string nm);
      @(negedge CLK);
      P_DATA = v.data; PAR_EN = v.pe; PAR_TYP = v.pt; STOP2 = v.s2;
      set_empty(v.w7, 1'b0);
      #1;
      chk({nm, " rd_inc idle"}, 32'(g_rd(v.w7)), 1);
      chk({nm, " tx idle"},     32'(g_tx(v.w7)), 1);
      chk({nm, " busy idle"},   32'(g_busy(v.w7)), 0);
      @(negedge CLK);
      set_empty(v.w7, 1'b1);
      for (int i = 0; i < v.len; i++) begin
         #1;
         chk($sformatf("%s tx[%0d]", nm, i),   32'(g_tx(v.w7)), 32'(v.exp[i]));
         chk($sformatf("%s busy[%0d]", nm, i), 32'(g_busy(v.w7)), 1);
         chk($sformatf("%s rd[%0d]", nm, i),   32'(g_rd(v.w7)), 0);
         @(negedge CLK);
      end
      #1;
      chk({nm, " tx after"},   32'(g_tx(v.w7)), 1);
      chk({nm, " busy after"}, 32'(g_busy(v.w7)), 0);
   endtask

   // Two frames; second word and config presented at cycle chg of frame 1.
   task automatic two_frames(input logic [8:0] d1, input logic pe1, input logic s21,
                             input int chg, input logic [8:0] d2, input logic pe2,
                             input logic pt2, input logic s22, input int stop_idx,
                             input int len, input logic [0:21] exp, input string nm);
      int pops;
      @(negedge CLK);
      P_DATA = d1; PAR_EN = pe1; PAR_TYP = 1'b0; STOP2 = s21; f_empty = 1'b0;
      #1;
      chk({nm, " rd_inc idle"}, 32'(rd8), 1);
      pops = 32'(rd8);
      @(negedge CLK);
      for (int i = 0; i < len; i++) begin
         if (i == 0) f_empty = 1'b1;
         if (i == chg) begin
            P_DATA = d2; PAR_EN = pe2; PAR_TYP = pt2; STOP2 = s22; f_empty = 1'b0;
         end
         if (i == stop_idx + 1) f_empty = 1'b1;
         #1;
         chk($sformatf("%s tx[%0d]", nm, i),   32'(tx8), 32'(exp[i]));
         chk($sformatf("%s busy[%0d]", nm, i), 32'(busy8), 1);
         chk($sformatf("%s rd[%0d]", nm, i),   32'(rd8), (i == stop_idx) ? 1 : 0);
         pops += 32'(rd8);
         @(negedge CLK);
      end
      #1;
      chk({nm, " tx after"},   32'(tx8), 1);
      chk({nm, " busy after"}, 32'(busy8), 0);
      chk({nm, " pops"},       32'(pops), 2);
   endtask

   initial begin
      vecs[0] = '{9'h0A5, 1'b0, 1'b0, 1'b0, 10, 12'b0101001011_00, 1'b0};
      vecs[1] = '{9'h080, 1'b1, 1'b0, 1'b1, 12, 12'b000000001111,  1'b0};
      vecs[2] = '{9'h080, 1'b1, 1'b1, 1'b1, 12, 12'b000000001011,  1'b0};
      vecs[3] = '{9'h0A5, 1'b1, 1'b0, 1'b1, 12, 12'b010100101011,  1'b0};
      vecs[4] = '{9'h03C, 1'b1, 1'b1, 1'b0, 11, 12'b00011110011_0, 1'b0};
      vecs[5] = '{9'h000, 1'b0, 1'b0, 1'b1, 11, 12'b00000000011_0, 1'b0};
      vecs[6] = '{9'h055, 1'b1, 1'b1, 1'b0, 10, 12'b0101010111_00, 1'b1};

      RST = 1'b0; f_empty = 1'b1; f_empty7 = 1'b1;
      P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      chk("reset tx8",   32'(tx8), 1);
      chk("reset busy8", 32'(busy8), 0);
      chk("reset rd8",   32'(rd8), 0);
      chk("reset tx7",   32'(tx7), 1);
      f_empty = 1'b0;
      #1;
      chk("reset rd8 gated", 32'(rd8), 0);
      f_empty = 1'b1;
      @(negedge CLK);
      RST = 1'b1;

      for (int k = 0; k < 7; k++)
         run_frame(vecs[k], $sformatf("vec%0d", k));

      two_frames(9'h001, 1'b0, 1'b0, 0, 9'h0FE, 1'b0, 1'b0, 1'b0, 9, 20,
                 22'b0100000001_0011111111_00, "b2b");

      two_frames(9'h05A, 1'b0, 1'b0, 4, 9'h00F, 1'b1, 1'b0, 1'b1, 9, 22,
                 22'b0010110101_011110000011, "cfgchg");

      // Reset during data bit 3 of an 0xA5 frame.
      @(negedge CLK);
      P_DATA = 9'h0A5; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; f_empty = 1'b0;
      @(negedge CLK);
      f_empty = 1'b1;
      repeat (4) @(negedge CLK);
      #1;
      chk("rst pre tx",   32'(tx8), 0);
      chk("rst pre busy", 32'(busy8), 1);
      RST = 1'b0;
      #1;
      chk("rst tx",   32'(tx8), 1);
      chk("rst busy", 32'(busy8), 0);
      chk("rst rd",   32'(rd8), 0);
      f_empty = 1'b0;
      #1;
      chk("rst rd nonempty", 32'(rd8), 0);
      @(negedge CLK);
      f_empty = 1'b1;
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         #1;
         chk($sformatf("post rst tx[%0d]", i),   32'(tx8), 1);
         chk($sformatf("post rst busy[%0d]", i), 32'(busy8), 0);
         chk($sformatf("post rst rd[%0d]", i),   32'(rd8), 0);
      end
      run_frame('{9'h0C3, 1'b0, 1'b0, 1'b0, 10, 12'b0110000111_00, 1'b0}, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
- Parametrised UART transmit engine, next generation of the UART_TX controller.
- Merges the control FSM, bit serializer, parity generator and output mux into one block.
- Adds configurable data width, odd/even parity, 1 or 2 stop bits, an explicit FIFO read strobe and back-to-back framing with no idle gap.
- Sits between the TX async FIFO read port (first-word-fall-through) and the UART TX pin; advances one bit per CLK cycle, where CLK is the TX bit clock.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
- CNT_W, $clog2(DATA_WIDTH), width of the internal data-bit counter; derived, not overridden.

Ports:
- CLK  in  1  TX bit clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- P_DATA  in  DATA_WIDTH  FIFO read-port word; valid whenever f_empty=0.
- f_empty  in  1  FIFO empty flag; 0 means a word is available.
- PAR_EN  in  1  1 = insert parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  0 = one stop bit, 1 = two stop bits.
- rd_inc  out  1  one-cycle FIFO pop strobe, combinational from state and f_empty.
- TX_OUT  out  1  serial line, registered, idles high.
- busy  out  1  registered; high for every cycle of a frame.

Behaviour:
- Reset: state=IDLE, TX_OUT=1, busy=0, rd_inc=0, counter=0, shift register=0. Reset takes effect immediately, including mid-frame; the in-flight word is dropped.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Accept condition: rd_inc=1 in a cycle that is (IDLE or last stop cycle) and f_empty=0.
- On the accept edge, the block captures:
  - P_DATA into the shift register;
  - PAR_EN, PAR_TYP and STOP2 into frame-config registers;
  - parity = ^P_DATA XOR PAR_TYP.
- Config inputs are ignored at all other times; changes mid-frame affect only the next frame.
- Line timing: TX_OUT and busy take the value of the state being entered on each edge, so TX_OUT is exactly one bit time per state cycle. First start-bit cycle = cycle after the accept edge.
- IDLE: TX_OUT=1, busy=0; go to START on accept.
- START: TX_OUT=0, one cycle, then DATA.
- DATA: TX_OUT=shift[0], LSB first; shift right and increment counter each cycle.
  - Exactly DATA_WIDTH cycles.
  - After counter==DATA_WIDTH-1, go to PARITY if latched PAR_EN, else STOP1.
  - Counter clears on exit.
- PARITY: TX_OUT=latched parity bit, one cycle, then STOP1.
- STOP1: TX_OUT=1.
  - If latched STOP2=1, go to STOP2.
  - Else this is the last stop cycle: accept -> START directly (no idle bit, busy stays 1); otherwise IDLE.
- STOP2 state: TX_OUT=1; last stop cycle; same accept/IDLE rule as STOP1.
- Frame length = 1 + DATA_WIDTH + PAR_EN + (STOP2 ? 2 : 1) cycles.
- busy=1 from the first start-bit cycle through the last stop cycle.
- rd_inc is never asserted in START, DATA or PARITY, even when f_empty=0. Exactly one rd_inc per transmitted frame.
- f_empty rising after accept has no effect on the current frame.
- Illegal or unreachable state encoding: next state IDLE, TX_OUT=1, busy=0.

Test Plan:
- DATA_WIDTH=8, PAR_EN=0, STOP2=0, push 0xA5 into idle block -> rd_inc for 1 cycle; TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; busy high for exactly those 10 cycles; then TX_OUT=1, busy=0.
- PAR_EN=1, PAR_TYP=0, STOP2=1, word 0x80 -> TX_OUT = 0,0,0,0,0,0,0,0,1, parity 1, stop 1,1 (12 cycles). Repeat with PAR_TYP=1 -> parity bit 0. Word 0xA5 with PAR_TYP=0 gives parity 0.
- Two words 0x01, 0xFE queued, PAR_EN=0, STOP2=0 -> rd_inc in the idle cycle and again in frame 1's stop cycle. Second start bit immediately follows the first stop bit (20 contiguous busy cycles). FIFO popped exactly twice.
- Toggle PAR_EN 0->1 and STOP2 0->1 during DATA of frame 1 -> frame 1 is 10 cycles with no parity bit; the following frame carries parity and two stop bits.
- Assert RST low during data bit 3 -> TX_OUT=1, busy=0, rd_inc=0 asynchronously. After release with f_empty=1, block stays IDLE; with f_empty=0, a fresh frame starts with a new rd_inc.
- Instantiate DATA_WIDTH=7, word 7'h55, PAR_EN=1, PAR_TYP=1 -> TX_OUT = 0,1,0,1,0,1,0,1, parity 1, stop 1 (10 cycles). Counter terminates after 7 data bits.
